// File: rtl/pipelined_trace_unit_pkg.sv
// Shared record layout for the instruction trace path; field widths are the
// parameter defaults of the trace unit, narrower instances zero-extend into them.
package ryuki_datatypes;
    localparam int TRACE_ADDR_W = 32;
    localparam int TRACE_DATA_W = 32;
    localparam int TRACE_TS_W   = 32;

    typedef struct packed {
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] instr;
        logic [TRACE_TS_W-1:0]   if_start;
        logic [TRACE_TS_W-1:0]   if_end;
        logic [TRACE_TS_W-1:0]   id_start;
    } trace_output;
endpackage

// File: rtl/trace_fifo.sv
// In-order queue, head visible combinationally; push and pop may share a cycle,
// and a pop frees the slot for a same-cycle push even when full.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (cnt_q != '0);
        do_push  = push && ((cnt_q != FULL_CNT) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/pipelined_trace_unit.sv
// Timestamps fetch grant / rvalid / decode-start of each instruction through three
// in-order queues; a record is valid the cycle after its decode edge, held until accepted.
module pipelined_trace_unit
    import ryuki_datatypes::*;
#(
    parameter int ADDR_WIDTH      = TRACE_ADDR_W,
    parameter int DATA_WIDTH      = TRACE_DATA_W,
    parameter int TS_WIDTH        = TRACE_TS_W,
    parameter int MAX_OUTSTANDING = 4,
    parameter int FETCH_DEPTH     = 4,
    parameter int OUT_DEPTH       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trace_en,
    input  logic                  instr_req,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic                  instr_grant,
    input  logic                  instr_rvalid,
    input  logic [DATA_WIDTH-1:0] instr_rdata,
    input  logic                  is_decoding,
    output logic                  trace_data_valid,
    input  logic                  trace_data_accept,
    output trace_output           trace_data_o,
    output logic [15:0]           overflow_count,
    output logic                  protocol_error
);
    localparam int PEND_W  = ADDR_WIDTH + TS_WIDTH;
    localparam int FETCH_W = ADDR_WIDTH + DATA_WIDTH + 2 * TS_WIDTH;
    localparam int OUT_W   = $bits(trace_output);
    localparam logic [TS_WIDTH-1:0] TS_ONE = TS_WIDTH'(1);

    logic [TS_WIDTH-1:0] counter_q, counter_d;
    logic                dec_prev_q, dec_prev_d;
    logic [15:0]         ovf_q, ovf_d;
    logic                err_q, err_d;

    logic               pend_push, pend_pop, pend_full, pend_empty;
    logic [PEND_W-1:0]  pend_in, pend_head;
    logic               fetch_push, fetch_pop, fetch_full, fetch_empty;
    logic [FETCH_W-1:0] fetch_in, fetch_head;
    logic               out_push, out_pop, out_full, out_empty;
    logic [OUT_W-1:0]   out_head;

    logic                  grant_evt, dec_edge;
    logic [1:0]            drops;
    logic [16:0]           ovf_sum;
    trace_output           out_rec;
    logic [ADDR_WIDTH-1:0] f_addr;
    logic [DATA_WIDTH-1:0] f_instr;
    logic [TS_WIDTH-1:0]   f_if_start, f_if_end;

    always_comb begin
        grant_evt  = instr_req && instr_grant && trace_en;
        dec_edge   = is_decoding && !dec_prev_q;

        pend_push  = grant_evt;
        pend_pop   = instr_rvalid && !pend_empty;
        pend_in    = {instr_addr, counter_q};

        fetch_push = pend_pop;
        fetch_in   = {pend_head, instr_rdata, counter_q};
        fetch_pop  = dec_edge && !fetch_empty;

        {f_addr, f_if_start, f_instr, f_if_end} = fetch_head;
        out_rec.addr     = TRACE_ADDR_W'(f_addr);
        out_rec.instr    = TRACE_DATA_W'(f_instr);
        out_rec.if_start = TRACE_TS_W'(f_if_start);
        out_rec.if_end   = TRACE_TS_W'(f_if_end);
        out_rec.id_start = TRACE_TS_W'(counter_q);
        out_push = fetch_pop;
        out_pop  = !out_empty && trace_data_accept;

        // A push is lost only when its queue is full and nothing leaves that cycle.
        drops = 2'(pend_push  && pend_full  && !pend_pop)
              + 2'(fetch_push && fetch_full && !fetch_pop)
              + 2'(out_push   && out_full   && !out_pop);
        ovf_sum = {1'b0, ovf_q} + {15'd0, drops};
        ovf_d   = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];

        err_d      = err_q || (instr_rvalid && pend_empty) || (dec_edge && fetch_empty);
        counter_d  = counter_q + TS_ONE;
        dec_prev_d = is_decoding;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q  <= '0;
            dec_prev_q <= 1'b1;
            ovf_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            counter_q  <= counter_d;
            dec_prev_q <= dec_prev_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
        end
    end

    trace_fifo #(.WIDTH(PEND_W), .DEPTH(MAX_OUTSTANDING)) u_pend (
        .clk(clk), .rst(rst), .push(pend_push), .push_dat(pend_in), .pop(pend_pop),
        .full(pend_full), .empty(pend_empty), .head(pend_head)
    );

    trace_fifo #(.WIDTH(FETCH_W), .DEPTH(FETCH_DEPTH)) u_fetch (
        .clk(clk), .rst(rst), .push(fetch_push), .push_dat(fetch_in), .pop(fetch_pop),
        .full(fetch_full), .empty(fetch_empty), .head(fetch_head)
    );

    trace_fifo #(.WIDTH(OUT_W), .DEPTH(OUT_DEPTH)) u_out (
        .clk(clk), .rst(rst), .push(out_push), .push_dat(out_rec), .pop(out_pop),
        .full(out_full), .empty(out_empty), .head(out_head)
    );

    assign trace_data_valid = !out_empty;
    assign trace_data_o     = out_empty ? '0 : out_head;
    assign overflow_count   = ovf_q;
    assign protocol_error   = err_q;
endmodule

// File: tb/tb_pipelined_trace_unit.sv
// Checks the trace unit against a queue-based reference model plus directed scenarios.
module tb_pipelined_trace_unit;
    import ryuki_datatypes::*;

    localparam int MAXO = 4;
    localparam int FD   = 4;
    localparam int OD   = 8;

    logic        clk = 1'b0;
    logic        rst, trace_en, instr_req, instr_grant, instr_rvalid, is_decoding, trace_data_accept;
    logic [31:0] instr_addr, instr_rdata;
    logic        vld, vld4, err, err4;
    logic [15:0] ovf, ovf4;
    trace_output dat, dat4;

    always #5 clk = ~clk;

    pipelined_trace_unit dut (
        .clk(clk), .rst(rst), .trace_en(trace_en), .instr_req(instr_req),
        .instr_addr(instr_addr), .instr_grant(instr_grant), .instr_rvalid(instr_rvalid),
        .instr_rdata(instr_rdata), .is_decoding(is_decoding), .trace_data_valid(vld),
        .trace_data_accept(trace_data_accept), .trace_data_o(dat),
        .overflow_count(ovf), .protocol_error(err)
    );

    pipelined_trace_unit #(.TS_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .trace_en(trace_en), .instr_req(instr_req),
        .instr_addr(instr_addr), .instr_grant(instr_grant), .instr_rvalid(instr_rvalid),
        .instr_rdata(instr_rdata), .is_decoding(is_decoding), .trace_data_valid(vld4),
        .trace_data_accept(trace_data_accept), .trace_data_o(dat4),
        .overflow_count(ovf4), .protocol_error(err4)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: queues of partially filled records, cycle count since reset.
    trace_output pend_m[$], fetch_m[$], out_m[$];
    int unsigned cnt_m;
    bit          prev_m;
    int          ovf_m;
    bit          err_m;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_step();
        trace_output g, r, f;
        int  drops;
        bit  do_fetch, do_out;
        if (rst) begin
            pend_m.delete(); fetch_m.delete(); out_m.delete();
            cnt_m = 0; prev_m = 1'b1; ovf_m = 0; err_m = 1'b0;
            return;
        end
        drops = 0; do_fetch = 1'b0; do_out = 1'b0;
        r = '0; f = '0; g = '0;
        if (instr_rvalid) begin
            if (pend_m.size() == 0) err_m = 1'b1;
            else begin
                r = pend_m.pop_front();
                r.instr = instr_rdata;
                r.if_end = cnt_m;
                do_fetch = 1'b1;
            end
        end
        if (is_decoding && !prev_m) begin
            if (fetch_m.size() == 0) err_m = 1'b1;
            else begin
                f = fetch_m.pop_front();
                f.id_start = cnt_m;
                do_out = 1'b1;
            end
        end
        if (trace_data_accept && out_m.size() > 0) void'(out_m.pop_front());
        if (trace_en && instr_req && instr_grant) begin
            g.addr = instr_addr;
            g.if_start = cnt_m;
            if (pend_m.size() < MAXO) pend_m.push_back(g); else drops++;
        end
        if (do_fetch) begin
            if (fetch_m.size() < FD) fetch_m.push_back(r); else drops++;
        end
        if (do_out) begin
            if (out_m.size() < OD) out_m.push_back(f); else drops++;
        end
        ovf_m  = (ovf_m + drops > 65535) ? 65535 : ovf_m + drops;
        prev_m = is_decoding;
        cnt_m++;
    endfunction

    task automatic step();
        trace_output exp_dat;
        model_step();
        @(posedge clk);
        #1;
        exp_dat = (out_m.size() > 0) ? out_m[0] : '0;
        chk("m_valid", vld, out_m.size() > 0);
        chk("m_data", dat, exp_dat);
        chk("m_ovf", ovf, ovf_m);
        chk("m_err", err, err_m);
        chk("m4_valid", vld4, out_m.size() > 0);
        chk("m4_ovf", ovf4, ovf_m);
        chk("m4_err", err4, err_m);
    endtask

    task automatic drive(input bit req, input bit rv, input bit dec, input bit acc,
                         input logic [31:0] addr, input logic [31:0] data);
        instr_req = req; instr_grant = req; instr_addr = addr;
        instr_rvalid = rv; instr_rdata = data;
        is_decoding = dec; trace_data_accept = acc;
        step();
    endtask

    task automatic do_reset(input bit dec);
        rst = 1'b1;
        drive(0, 0, dec, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
        drive(1, 0, 0, 0, addr, 0);
        drive(0, 1, 0, 0, 0, data);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit          req;
        bit          rv;
        logic [31:0] rdata;
        bit          dec;
        bit          acc;
        bit          exp_vld;
        bit          exp_err;
    } vec_t;

    vec_t        tbl[11];
    trace_output exp_rec, held;

    initial begin
        for (int i = 0; i < 11; i++) tbl[i] = '{0, 0, 32'h0, 0, 0, 0, 0};
        tbl[5]  = '{1, 0, 32'h0,        0, 0, 0, 0};
        tbl[7]  = '{0, 1, 32'h00000013, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 32'h0,        1, 0, 1, 0};
        tbl[10] = '{0, 0, 32'h0,        0, 1, 0, 0};

        rst = 1'b1; trace_en = 1'b1; instr_req = 0; instr_grant = 0; instr_addr = 0;
        instr_rvalid = 0; instr_rdata = 0; is_decoding = 0; trace_data_accept = 0;

        // Reset values and single fetch timeline
        do_reset(1'b0);
        chk("rst_valid", vld, 1'b0);
        chk("rst_data", dat, '0);
        chk("rst_ovf", ovf, 16'd0);
        chk("rst_err", err, 1'b0);
        exp_rec = '{addr: 32'h1000, instr: 32'h13, if_start: 32'd5, if_end: 32'd7, id_start: 32'd9};
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].req, tbl[i].rv, tbl[i].dec, tbl[i].acc, 32'h1000, tbl[i].rdata);
            chk("tbl_valid", vld, tbl[i].exp_vld);
            chk("tbl_err", err, tbl[i].exp_err);
            if (i == 9) chk("single_fetch_rec", dat, exp_rec);
        end

        // Overflow of the pending queue
        do_reset(1'b0);
        for (int k = 0; k < 5; k++) drive(1, 0, 0, 0, 32'h100 + k, 0);
        chk("ovf_5_grants", ovf, 16'd1);
        for (int k = 0; k < 4; k++) drive(0, 1, 0, 0, 0, 32'hA0 + k);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1, 0, 0, 0);
            drive(0, 0, 0, 0, 0, 0);
        end
        chk("ovf_drain_addr", dat.addr, 32'h100);
        chk("ovf_still_1", ovf, 16'd1);

        // Rvalid without a grant
        do_reset(1'b0);
        drive(0, 1, 0, 0, 0, 32'hDEAD);
        chk("orphan_err", err, 1'b1);
        chk("orphan_no_rec", vld, 1'b0);
        fetch_one(32'h2000, 32'h33);
        chk("after_err_instr", dat.instr, 32'h33);
        chk("after_err_addr", dat.addr, 32'h2000);
        chk("err_sticky", err, 1'b1);

        // Full output FIFO, hold then drain in order
        do_reset(1'b0);
        for (int k = 0; k < 8; k++) fetch_one(32'h3000 + k, k + 1);
        held = dat;
        chk("full_head_instr", held.instr, 32'd1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk("hold_stable", dat, held);
        end
        for (int k = 0; k < 8; k++) begin
            chk("drain_valid", vld, 1'b1);
            chk("drain_order", dat.instr, k + 1);
            drive(0, 0, 0, 1, 0, 0);
        end
        chk("drained_empty", vld, 1'b0);

        // Timestamp wrap in the 4-bit instance
        do_reset(1'b0);
        for (int k = 0; k < 15; k++) drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 32'h44, 0);
        drive(0, 1, 0, 0, 0, 32'h55);
        drive(0, 0, 1, 0, 0, 0);
        chk("wrap_if_start", dat4.if_start, 32'd15);
        chk("wrap_if_end", dat4.if_end, 32'd0);
        chk("wrap_id_start", dat4.id_start, 32'd1);
        chk("nowrap_if_end", dat.if_end, 32'd16);

        // Reset with traffic in flight, decode held high across release
        do_reset(1'b0);
        drive(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) fetch_one(32'h5000 + k, 32'h70 + k);
        drive(1, 0, 0, 0, 32'h6000, 0);
        drive(1, 0, 0, 0, 32'h6001, 0);
        chk("pre_rst_valid", vld, 1'b1);
        do_reset(1'b1);
        chk("rst2_valid", vld, 1'b0);
        chk("rst2_data", dat, '0);
        chk("rst2_ovf", ovf, 16'd0);
        chk("rst2_err", err, 1'b0);
        drive(1, 0, 1, 0, 32'h7000, 0);
        drive(0, 1, 1, 0, 0, 32'h77);
        drive(0, 0, 0, 0, 0, 0);
        chk("held_dec_no_rec", vld, 1'b0);
        chk("held_dec_no_err", err, 1'b0);
        drive(0, 0, 1, 0, 0, 0);
        exp_rec = '{addr: 32'h7000, instr: 32'h77, if_start: 32'd0, if_end: 32'd1, id_start: 32'd3};
        chk("post_rst_rec", dat, exp_rec);

        // Randomized traffic against the model
        do_reset(1'b0);
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 399) == 0);
            trace_en = ($urandom_range(0, 9) != 0);
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                  $urandom, $urandom);
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pipelined_trace_unit.md
PIPELINED_TRACE_UNIT -- requirements
Module: pipelined_trace_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: instruction address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: instruction data width.
REQ-003 SHALL have parameter TS_WIDTH, default 32: timestamp/counter width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, power of two ≥2: depth of the granted-awaiting-rvalid queue.
REQ-005 SHALL have parameter FETCH_DEPTH, default 4, power of two ≥2: depth of the fetched-awaiting-decode queue.
REQ-006 SHALL have parameter OUT_DEPTH, default 8, power of two ≥2: depth of the output record FIFO.
REQ-007 Ports, in this order:
- clk  in  1  — the single clock.
- rst  in  1  — synchronous, active-high reset.
- trace_en  in  1  — capture enable.
- instr_req  in  1  — fetch request.
- instr_addr  in  ADDR_WIDTH  — fetch address.
- instr_grant  in  1  — fetch grant.
- instr_rvalid  in  1  — fetch data valid.
- instr_rdata  in  DATA_WIDTH  — fetch data.
- is_decoding  in  1  — ID stage busy.
- trace_data_valid  out  1  — output record available.
- trace_data_accept  in  1  — consumer takes the record.
- trace_data_o  out  trace_output  — head record.
- overflow_count  out  16  — total dropped events.
- protocol_error  out  1  — sticky protocol fault.

Function
REQ-008 SHALL maintain a free-running counter of TS_WIDTH bits: 0 in the first cycle after reset, +1 every cycle, wrapping from all-ones to 0 without flagging.
REQ-009 Every timestamp SHALL be the counter value in the cycle the event is sampled.
REQ-010 Grant event: a cycle with instr_req && instr_grant && trace_en.
- SHALL push {addr=instr_addr, if_start=counter} into the pending queue.
REQ-011 Rvalid event: instr_rvalid high.
- SHALL pop the pending head.
- SHALL push {addr, if_start, instr=instr_rdata, if_end=counter} into the fetched queue.
REQ-012 Decode event: rising edge of is_decoding (is_decoding high, registered previous value low).
- SHALL pop the fetched head, add id_start=counter, and push the record into the output FIFO.
REQ-013 All three queues SHALL be strictly in order (FIFO).
- Each queue SHALL accept a push and a pop in the same cycle, including when full or empty.
- A same-cycle pop frees space for that cycle's push.
REQ-014 Push to a full queue (after any same-cycle pop) SHALL drop the entry and increment overflow_count, saturating at 16'hFFFF.
- More than one drop in a cycle SHALL add the number of drops.
REQ-015 Rvalid with the pending queue empty, or decode edge with the fetched queue empty, SHALL be ignored and SHALL set protocol_error.
- protocol_error SHALL clear only on reset.
REQ-016 Latency:
- Fetched entry usable by a decode edge from the cycle after rvalid.
- Output FIFO empty → trace_data_valid high the cycle after the decode edge.
REQ-017 Output handshake:
- trace_data_valid = output FIFO not empty.
- trace_data_o = head record, held stable while valid && !accept.
- valid && accept pops the head at the clock edge.
- accept while not valid SHALL have no effect.
REQ-018 With trace_en low, grant events SHALL NOT be captured; rvalid and decode events SHALL still drain queued entries.

Reset
REQ-019 rst high at a clock edge SHALL, regardless of in-flight events:
- set counter to 0,
- empty all queues,
- set trace_data_valid to 0 and trace_data_o to all zeros,
- set overflow_count to 0 and protocol_error to 0,
- set the registered is_decoding value to 1, so a decode already high at reset release is not an edge.
REQ-020 Events coincident with an asserted rst SHALL be discarded.

Structure
REQ-021 trace_output typedef (addr, instr, if_start, if_end, id_start) SHALL live in package ryuki_datatypes.
- Widths SHALL come from package constants matching the parameter defaults.
REQ-022 SHALL instantiate one generic sub-module trace_fifo (parametrised WIDTH, DEPTH; push/pop/full/empty/head) three times.

Verification
REQ-023 Single fetch: grant at counter 5, rvalid at 7 with rdata 32'h00000013, decode edge at 9 → one record {if_start 5, if_end 7, id_start 9}, valid at cycle 10.
REQ-024 Five back-to-back grants with MAX_OUTSTANDING=4 and no rvalid → 4 entries queued, overflow_count=1.
REQ-025 Rvalid with no prior grant → protocol_error=1, no record produced, later normal fetch traced correctly.
REQ-026 Output FIFO full (8 records), accept held low for 3 cycles then high → trace_data_o stable over those 3 cycles, then records drain in order 1..8, one per cycle.
REQ-027 TS_WIDTH=4, grant at counter 15, rvalid one cycle later → if_end=0.
REQ-028 rst asserted with 2 pending and 3 output records → all outputs zero the next cycle, counter=0, is_decoding held high through reset creates no record.
